cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 152 +++++++++++++++
 tb/tb_cache_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares one cache slave port between NUM_PORTS master ports. An idle
// arbiter picks one valid master and copies its request into a request
// register. It then holds that request on the slave side until the cache
// answers with s_ready_i. Masters are picked by round-robin or by fixed
// priority, where port 0 is highest.
//
// Parameters
//   NUM_PORTS   number of master ports (1..8)
//   ADDR_SIZE   address width
//   WORD_SIZE   data width
//   FIXED_PRIO  0 = round-robin, 1 = fixed priority (port 0 highest)
//
// Ports
//   clk_i, reset_i     clock and asynchronous active-high reset
//   m_addr_i           per-port request address
//   m_wr_data_i        per-port write data
//   m_wr_size_i        per-port write size (cache_access_size_t encoding)
//   m_write_i          per-port write (1) / read (0)
//   m_valid_i          per-port request valid
//   m_rd_data_o        read data, broadcast to every port
//   m_ready_o          per-port completion strobe (granted port only)
//   m_miss_o           per-port miss indication (granted port only)
//   s_addr_o .. s_valid_o    request towards the shared cache
//   s_rd_data_i, s_ready_i, s_miss_i   response from the shared cache
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_SIZE  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [NUM_PORTS-1:0][ADDR_SIZE-1:0]   m_addr_i,
    input  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]   m_wr_data_i,
    input  logic [NUM_PORTS-1:0][1:0]             m_wr_size_i,
    input  logic [NUM_PORTS-1:0]                  m_write_i,
    input  logic [NUM_PORTS-1:0]                  m_valid_i,
    output logic [WORD_SIZE-1:0]                  m_rd_data_o,
    output logic [NUM_PORTS-1:0]                  m_ready_o,
    output logic [NUM_PORTS-1:0]                  m_miss_o,
    output logic [ADDR_SIZE-1:0]                  s_addr_o,
    output logic [WORD_SIZE-1:0]                  s_wr_data_o,
    output logic [1:0]                            s_wr_size_o,
    output logic                                  s_write_o,
    output logic                                  s_valid_o,
    input  logic [WORD_SIZE-1:0]                  s_rd_data_i,
    input  logic                                  s_ready_i,
    input  logic                                  s_miss_i
);

    // A single port still needs a 1-bit index so the registers stay legal.
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wr_data;
    logic [1:0]           req_wr_size;
    logic                 req_write;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_found;
    logic [IDX_W-1:0]     cand_idx;
    int                   cand;

    // Search for the first valid port. Round-robin starts at the pointer and
    // wraps. Fixed priority always starts at port 0.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (FIXED_PRIO != 0) begin
                cand = i;
            end else begin
                cand = (int'(ptr) + i) % NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_found && m_valid_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            req_addr    <= '0;
            req_wr_data <= '0;
            req_wr_size <= '0;
            req_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state       <= BUSY;
                        grant       <= sel_idx;
                        req_addr    <= m_addr_i[sel_idx];
                        req_wr_data <= m_wr_data_i[sel_idx];
                        req_wr_size <= m_wr_size_i[sel_idx];
                        req_write   <= m_write_i[sel_idx];
                    end
                end
                BUSY: begin
                    // A miss alone does not end the transaction. Only the
                    // slave's ready does.
                    if (s_ready_i) begin
                        state <= IDLE;
                        if (grant == IDX_W'(NUM_PORTS - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= grant + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The slave side comes only from the request register, so master-side
    // changes cannot reach the cache during BUSY.
    assign s_valid_o   = (state == BUSY);
    assign s_addr_o    = req_addr;
    assign s_wr_data_o = req_wr_data;
    assign s_wr_size_o = req_wr_size;
    assign s_write_o   = req_write;
    assign m_rd_data_o = s_rd_data_i;

    // Only the granted port sees the slave's response, and only during BUSY.
    always_comb begin
        m_ready_o = '0;
        m_miss_o  = '0;
        if (state == BUSY) begin
            m_ready_o[grant] = s_ready_i;
            m_miss_o[grant]  = s_miss_i;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
//
// Directed bench for cache_arbiter. It uses three instances:
//   rr_dut : 2 ports, round-robin
//   fp_dut : 2 ports, fixed priority
//   q_dut  : 4 ports, round-robin (pointer wrap)
// All three instances share the clock, the reset and the slave response.
// An idle instance ignores the slave response.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

    logic clk;
    logic rst;

    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0][1:0]  m_size;
    logic [1:0]       m_write;
    logic [1:0]       v_rr;
    logic [1:0]       v_fp;

    logic [31:0] s_rd_data;
    logic        s_ready;
    logic        s_miss;

    logic [31:0] rr_rd_data, rr_saddr, rr_swdata;
    logic [1:0]  rr_ready, rr_miss, rr_ssize;
    logic        rr_swrite, rr_svalid;

    logic [31:0] fp_rd_data, fp_saddr, fp_swdata;
    logic [1:0]  fp_ready, fp_miss, fp_ssize;
    logic        fp_swrite, fp_svalid;

    logic [3:0][31:0] q_addr;
    logic [3:0][31:0] q_wdata;
    logic [3:0][1:0]  q_size;
    logic [3:0]       q_write;
    logic [3:0]       q_valid;
    logic [31:0]      q_rd_data, q_saddr, q_swdata;
    logic [3:0]       q_ready, q_miss;
    logic [1:0]       q_ssize;
    logic             q_swrite, q_svalid;

    int assertions;
    int failures;

    cache_arbiter #(.NUM_PORTS(2), .ADDR_SIZE(32), .WORD_SIZE(32), .FIXED_PRIO(0)) rr_dut (
        .clk_i(clk), .reset_i(rst),
        .m_addr_i(m_addr), .m_wr_data_i(m_wdata), .m_wr_size_i(m_size),
        .m_write_i(m_write), .m_valid_i(v_rr),
        .m_rd_data_o(rr_rd_data), .m_ready_o(rr_ready), .m_miss_o(rr_miss),
        .s_addr_o(rr_saddr), .s_wr_data_o(rr_swdata), .s_wr_size_o(rr_ssize),
        .s_write_o(rr_swrite), .s_valid_o(rr_svalid),
        .s_rd_data_i(s_rd_data), .s_ready_i(s_ready), .s_miss_i(s_miss)
    );

    cache_arbiter #(.NUM_PORTS(2), .ADDR_SIZE(32), .WORD_SIZE(32), .FIXED_PRIO(1)) fp_dut (
        .clk_i(clk), .reset_i(rst),
        .m_addr_i(m_addr), .m_wr_data_i(m_wdata), .m_wr_size_i(m_size),
        .m_write_i(m_write), .m_valid_i(v_fp),
        .m_rd_data_o(fp_rd_data), .m_ready_o(fp_ready), .m_miss_o(fp_miss),
        .s_addr_o(fp_saddr), .s_wr_data_o(fp_swdata), .s_wr_size_o(fp_ssize),
        .s_write_o(fp_swrite), .s_valid_o(fp_svalid),
        .s_rd_data_i(s_rd_data), .s_ready_i(s_ready), .s_miss_i(s_miss)
    );

    cache_arbiter #(.NUM_PORTS(4), .ADDR_SIZE(32), .WORD_SIZE(32), .FIXED_PRIO(0)) q_dut (
        .clk_i(clk), .reset_i(rst),
        .m_addr_i(q_addr), .m_wr_data_i(q_wdata), .m_wr_size_i(q_size),
        .m_write_i(q_write), .m_valid_i(q_valid),
        .m_rd_data_o(q_rd_data), .m_ready_o(q_ready), .m_miss_o(q_miss),
        .s_addr_o(q_saddr), .s_wr_data_o(q_swdata), .s_wr_size_o(q_ssize),
        .s_write_o(q_swrite), .s_valid_o(q_svalid),
        .s_rd_data_i(s_rd_data), .s_ready_i(s_ready), .s_miss_i(s_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one 2-port master request on the shared request buses.
    task automatic applyStimulus(input int port, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size,
                                 input logic wr);
        m_addr[port]  = addr;
        m_wdata[port] = data;
        m_size[port]  = size;
        m_write[port] = wr;
    endtask

    // Advances to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses reset between clock edges.
    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst        = 1'b1;
        m_addr     = '0;
        m_wdata    = '0;
        m_size     = '0;
        m_write    = '0;
        v_rr       = '0;
        v_fp       = '0;
        q_addr     = '0;
        q_wdata    = '0;
        q_size     = '0;
        q_write    = '0;
        q_valid    = '0;
        s_rd_data  = '0;
        s_ready    = 1'b0;
        s_miss     = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_svalid", 64'(rr_svalid), 64'd0);
        checkOutput("reset_ready", 64'(rr_ready), 64'd0);
        checkOutput("reset_saddr", 64'(rr_saddr), 64'd0);
        #10;
        rst = 1'b0;
        tick();

        // Single read on port 0
        $display("[TB] single read");
        applyStimulus(0, 32'h100, 32'h0, 2'd0, 1'b0);
        v_rr[0] = 1'b1;
        #1;
        checkOutput("read_idle_svalid", 64'(rr_svalid), 64'd0);
        tick();
        v_rr[0] = 1'b0;
        checkOutput("read_svalid", 64'(rr_svalid), 64'd1);
        checkOutput("read_saddr", 64'(rr_saddr), 64'h100);
        checkOutput("read_swrite", 64'(rr_swrite), 64'd0);
        checkOutput("read_ready_wait", 64'(rr_ready), 64'd0);
        tick();
        s_ready   = 1'b1;
        s_rd_data = 32'hDEADBEEF;
        #1;
        checkOutput("read_ready", 64'(rr_ready), 64'b01);
        checkOutput("read_rdata", 64'(rr_rd_data), 64'hDEADBEEF);
        tick();
        s_ready = 1'b0;
        #1;
        checkOutput("read_back_idle", 64'(rr_svalid), 64'd0);

        // Round-robin contention
        $display("[TB] round-robin contention");
        pulseReset();
        applyStimulus(0, 32'h1000, 32'h0, 2'd0, 1'b0);
        applyStimulus(1, 32'h2000, 32'h0, 2'd0, 1'b0);
        v_rr    = 2'b11;
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("rr_ready", 64'(rr_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            checkOutput("rr_saddr", 64'(rr_saddr), (k % 2 == 0) ? 64'h1000 : 64'h2000);
            tick();
            checkOutput("rr_gap_idle", 64'(rr_svalid), 64'd0);
        end
        v_rr    = 2'b00;
        s_ready = 1'b0;

        // Fixed priority
        $display("[TB] fixed priority");
        pulseReset();
        v_fp    = 2'b11;
        s_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("fp_ready", 64'(fp_ready), 64'b01);
            checkOutput("fp_saddr", 64'(fp_saddr), 64'h1000);
            tick();
        end
        v_fp[0] = 1'b0;
        tick();
        checkOutput("fp_port1", 64'(fp_ready), 64'b10);
        v_fp    = 2'b00;
        s_ready = 1'b0;
        tick();

        // Wrap on 4 ports: serve port 2 to move the pointer to 3
        $display("[TB] pointer wrap");
        pulseReset();
        q_addr[0]  = 32'hA0;
        q_addr[2]  = 32'hA2;
        q_addr[3]  = 32'hA3;
        q_valid[2] = 1'b1;
        s_ready    = 1'b1;
        tick();
        checkOutput("wrap_port2", 64'(q_ready), 64'b0100);
        q_valid = 4'b1001;
        tick();
        tick();
        checkOutput("wrap_port3", 64'(q_ready), 64'b1000);
        checkOutput("wrap_saddr3", 64'(q_saddr), 64'hA3);
        tick();
        tick();
        checkOutput("wrap_port0", 64'(q_ready), 64'b0001);
        checkOutput("wrap_saddr0", 64'(q_saddr), 64'hA0);
        q_valid = 4'b0000;
        s_ready = 1'b0;
        tick();
        tick();

        // Input changes during BUSY are ignored, and a miss without ready holds
        $display("[TB] busy input change");
        pulseReset();
        applyStimulus(1, 32'h40, 32'h55, 2'd2, 1'b1);
        v_rr[1] = 1'b1;
        tick();
        checkOutput("chg_saddr", 64'(rr_saddr), 64'h40);
        checkOutput("chg_swdata", 64'(rr_swdata), 64'h55);
        checkOutput("chg_ssize", 64'(rr_ssize), 64'd2);
        checkOutput("chg_swrite", 64'(rr_swrite), 64'd1);
        applyStimulus(1, 32'h80, 32'h99, 2'd0, 1'b0);
        v_rr[1] = 1'b0;
        tick();
        checkOutput("chg_hold_saddr", 64'(rr_saddr), 64'h40);
        checkOutput("chg_hold_swdata", 64'(rr_swdata), 64'h55);
        checkOutput("chg_hold_svalid", 64'(rr_svalid), 64'd1);
        s_miss = 1'b1;
        #1;
        checkOutput("miss_fwd", 64'(rr_miss), 64'b10);
        tick();
        checkOutput("miss_stay_busy", 64'(rr_svalid), 64'd1);
        s_miss  = 1'b0;
        s_ready = 1'b1;
        #1;
        checkOutput("chg_ready", 64'(rr_ready), 64'b10);
        checkOutput("chg_final_saddr", 64'(rr_saddr), 64'h40);
        tick();
        s_ready = 1'b0;
        checkOutput("chg_idle", 64'(rr_svalid), 64'd0);

        // Reset mid-BUSY: first move the pointer to 1, then abandon a port-1 request
        $display("[TB] reset mid-busy");
        applyStimulus(0, 32'h300, 32'h0, 2'd0, 1'b0);
        applyStimulus(1, 32'h400, 32'h0, 2'd0, 1'b0);
        v_rr    = 2'b01;
        s_ready = 1'b1;
        tick();
        v_rr    = 2'b10;
        tick();
        s_ready = 1'b0;
        tick();
        checkOutput("rst_pre_busy", 64'(rr_saddr), 64'h400);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_svalid", 64'(rr_svalid), 64'd0);
        checkOutput("rst_async_saddr", 64'(rr_saddr), 64'd0);
        v_rr = 2'b11;
        #1;
        rst = 1'b0;
        tick();
        checkOutput("rst_first_grant", 64'(rr_saddr), 64'h300);
        checkOutput("rst_first_svalid", 64'(rr_svalid), 64'd1);
        v_rr = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
